alu_seq: RTL and testbench

Parametrised multi-cycle ALU for the multicycle CPU datapath and successor to the 8-bit combinational ALU. Captures operands on a start strobe. Completes logic and add/sub operations in one cycle, and variable shifts and an optional multiply iteratively. Presents a registered result plus carry/zero/negative flags with a one-cycle done pulse. The controller FSM issues `start` and waits for `done` before latching `result`/`czn` into the register file and flag register.

---
 rtl/alu_seq_pkg.sv | 29 ++
 rtl/alu_mul_iter.sv | 46 ++++
 rtl/alu_seq.sv | 151 +++++++++++++++
 tb/tb_alu_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, FSM states and flag indices for alu_seq.
// Also provides the helper that packs the C/Z/N flags into the czn vector.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int C_IDX = 0;
  localparam int Z_IDX = 1;
  localparam int N_IDX = 2;

  function automatic logic [2:0] mk_czn(input logic c, input logic z, input logic n);
    logic [2:0] f;
    f        = '0;
    f[C_IDX] = c;
    f[Z_IDX] = z;
    f[N_IDX] = n;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add unsigned multiplier, one step per cycle, WIDTH steps after load.
// prod shows the product as it stands after the current step, so it is final while last is high.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] prod
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;

  // lo holds the unconsumed multiplier bits and fills with product bits from the top
  assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
  assign prod = {sum, lo[WIDTH-1:1]};
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else if (load) begin
      mcand <= a;
      hi    <= '0;
      lo    <= b;
      cnt   <= '0;
    end else if (step) begin
      hi  <= sum[WIDTH:1];
      lo  <= {sum[0], lo[WIDTH-1:1]};
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU; logic/add/sub done at T+1, shift by k at T+1+k, MUL at T+1+WIDTH.
// start is ignored while busy (no queueing); iterative multiply only when ALU_SEQ_MUL_EN is defined.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [2:0]       czn
);

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] sh_val;
  logic [WIDTH-1:0] sh_next;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] one_res;
  logic [WIDTH:0]   sum_ext;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   shamt;
  logic [2:0]       czn_q;
  logic             one_c;
  logic             sh_out;
  logic             start_ok;
  logic             is_shift;
  logic             multi;

  assign start_ok = start && (state != S_RUN);
  assign shamt    = b[SHW-1:0];
  assign is_shift = (op == OP_SHL) || (op == OP_SHR);

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0]   hi_q;
  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_last;

  assign multi     = (is_shift && (shamt != '0)) || (op == OP_MUL);
  assign result_hi = hi_q;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .load (start_ok && (op == OP_MUL)),
    .step ((state == S_RUN) && (op_q == OP_MUL)),
    .a    (a),
    .b    (b),
    .last (mul_last),
    .prod (mul_prod)
  );
`else
  assign multi     = is_shift && (shamt != '0);
  assign result_hi = '0;
`endif

  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  assign result = res_q;
  assign czn    = czn_q;

  always_comb begin
    sum_ext = '0;
    one_res = '0;
    one_c   = 1'b0;
    case (op)
      OP_ADD: begin
        sum_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        one_res = sum_ext[WIDTH-1:0];
        one_c   = sum_ext[WIDTH];
      end
      OP_SUB: begin
        sum_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        one_res = sum_ext[WIDTH-1:0];
        one_c   = sum_ext[WIDTH];
      end
      OP_AND:         one_res = a & b;
      OP_OR:          one_res = a | b;
      OP_XOR:         one_res = a ^ b;
      // only reached here for a shift by zero
      OP_SHL, OP_SHR: one_res = a;
      default:        one_res = '0;
    endcase
  end

  assign sh_next = (op_q == OP_SHL) ? {sh_val[WIDTH-2:0], 1'b0} : {1'b0, sh_val[WIDTH-1:1]};
  assign sh_out  = (op_q == OP_SHL) ? sh_val[WIDTH-1] : sh_val[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= OP_ADD;
      sh_val <= '0;
      cnt    <= '0;
      res_q  <= '0;
      czn_q  <= '0;
`ifdef ALU_SEQ_MUL_EN
      hi_q   <= '0;
`endif
    end else if (start_ok) begin
      op_q   <= op;
      sh_val <= a;
      cnt    <= shamt;
      if (multi) begin
        state <= S_RUN;
      end else begin
        state <= S_DONE;
        res_q <= one_res;
        czn_q <= mk_czn(one_c, one_res == '0, one_res[WIDTH-1]);
`ifdef ALU_SEQ_MUL_EN
        hi_q  <= '0;
`endif
      end
    end else if (state == S_RUN) begin
`ifdef ALU_SEQ_MUL_EN
      if (op_q == OP_MUL) begin
        if (mul_last) begin
          state <= S_DONE;
          res_q <= mul_prod[WIDTH-1:0];
          hi_q  <= mul_prod[2*WIDTH-1:WIDTH];
          czn_q <= mk_czn(mul_prod[2*WIDTH-1:WIDTH] != '0, mul_prod == '0, mul_prod[WIDTH-1]);
        end
      end else
`endif
      begin
        sh_val <= sh_next;
        cnt    <= cnt - SHW'(1);
        if (cnt == SHW'(1)) begin
          state <= S_DONE;
          res_q <= sh_next;
          czn_q <= mk_czn(sh_out, sh_next == '0, sh_next[WIDTH-1]);
`ifdef ALU_SEQ_MUL_EN
          hi_q  <= '0;
`endif
        end
      end
    end else begin
      state <= S_IDLE;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: vector table, hand-written corner sequences and random ops against a reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cin;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [2:0]   czn;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] prev_res = '0;
  logic [W-1:0] prev_hi  = '0;
  logic [2:0]   prev_czn = '0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [2:0]   czn;
    int           lat;
  } vec_t;

  vec_t vq[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .czn       (czn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic [W-1:0] r, input logic [W-1:0] h,
                      input logic [2:0] f, input int l);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.cin = ci; v.res = r; v.hi = h; v.czn = f; v.lat = l;
    vq.push_back(v);
  endtask

  // Reference: plain integer arithmetic on the operation definitions.
  task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, output logic [W-1:0] r, output logic [W-1:0] h,
                       output logic [2:0] f, output int lat);
    int unsigned s;
    logic [2:0]  k;
    logic        c;
    logic        z;
    k = y[2:0];
    h = '0;
    c = 1'b0;
    lat = 1;
    s = 0;
    case (o)
      OP_ADD: begin s = x + y + ci; r = s[7:0]; c = s[8]; end
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_SUB: begin r = x - y; c = (x >= y); end
      OP_SHL: begin s = {24'b0, x} << k; r = s[7:0]; c = s[8]; lat = 1 + int'(k); end
      OP_SHR: begin r = x >> k; c = (k == 0) ? 1'b0 : x[k-1]; lat = 1 + int'(k); end
      default: begin
`ifdef ALU_SEQ_MUL_EN
        s = x * y; r = s[7:0]; h = s[15:8]; c = (h != 0); lat = 1 + W;
`else
        r = '0;
`endif
      end
    endcase
    z = (r == 0) && (h == 0);
    f = {r[W-1], z, c};
  endtask

  task automatic launch(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci);
    op = o; a = x; b = y; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op  = 3'($urandom);
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
  endtask

  // Entered in cycle T+1; leaves in the done cycle (or after the cycle bound).
  task automatic wait_done(input int inj, output int lat, output int bn, output logic hold);
    lat  = 1;
    bn   = 0;
    hold = 1'b1;
    while (!done && lat < 40) begin
      if (busy) bn++;
      if (result !== prev_res || czn !== prev_czn || result_hi !== prev_hi) hold = 1'b0;
      if (lat == inj) begin
        op = OP_AND; a = 8'hFF; b = 8'hFF; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic ci, input logic [W-1:0] er,
                         input logic [W-1:0] eh, input logic [2:0] ef, input int el, input int inj);
    int   lat;
    int   bn;
    logic hold;
    launch(o, x, y, ci);
    wait_done(inj, lat, bn, hold);
    chk({tag, " latency"}, 32'(lat), 32'(el));
    chk({tag, " result"}, 32'(result), 32'(er));
    chk({tag, " result_hi"}, 32'(result_hi), 32'(eh));
    chk({tag, " czn"}, 32'(czn), 32'(ef));
    chk({tag, " busy_cycles"}, 32'(bn), 32'(el - 1));
    if (el > 1) chk({tag, " hold_midop"}, 32'(hold), 32'(1));
    prev_res = er; prev_hi = eh; prev_czn = ef;
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 32'(done), 32'(0));
  endtask

  initial begin
    logic [2:0]   o;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         ci;
    logic [W-1:0] er;
    logic [W-1:0] eh;
    logic [2:0]   ef;
    int           el;
    int           lat;
    int           bn;
    int           dn;
    logic         hold;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset done", 32'(done), 32'(0));
    chk("reset result", 32'(result), 32'(0));
    chk("reset result_hi", 32'(result_hi), 32'(0));
    chk("reset czn", 32'(czn), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    addv(OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 3'b011, 1);
    addv(OP_SUB, 8'h05, 8'h07, 1'b0, 8'hFE, 8'h00, 3'b100, 1);
    addv(OP_SHL, 8'h81, 8'h03, 1'b0, 8'h08, 8'h00, 3'b000, 4);
    addv(OP_SHR, 8'h81, 8'h00, 1'b0, 8'h81, 8'h00, 3'b100, 1);
    addv(OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 3'b000, 1);
    addv(OP_OR,  8'hF0, 8'h0F, 1'b0, 8'hFF, 8'h00, 3'b100, 1);
    addv(OP_XOR, 8'hAA, 8'hAA, 1'b0, 8'h00, 8'h00, 3'b010, 1);
    addv(OP_ADD, 8'h7F, 8'h00, 1'b1, 8'h80, 8'h00, 3'b100, 1);
    addv(OP_SUB, 8'h33, 8'h33, 1'b0, 8'h00, 8'h00, 3'b011, 1);
    addv(OP_SHR, 8'h81, 8'h01, 1'b0, 8'h40, 8'h00, 3'b001, 2);
    addv(OP_SHL, 8'h81, 8'h0B, 1'b0, 8'h08, 8'h00, 3'b000, 4);
    addv(OP_SHR, 8'h80, 8'h07, 1'b0, 8'h01, 8'h00, 3'b000, 8);
`ifdef ALU_SEQ_MUL_EN
    addv(OP_MUL, 8'h10, 8'h10, 1'b0, 8'h00, 8'h01, 3'b001, 9);
    addv(OP_MUL, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 3'b001, 9);
`else
    addv(OP_MUL, 8'h10, 8'h10, 1'b0, 8'h00, 8'h00, 3'b010, 1);
    addv(OP_MUL, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 3'b010, 1);
`endif

    for (int i = 0; i < vq.size(); i++) begin
      run_vec($sformatf("vec%0d", i), vq[i].op, vq[i].a, vq[i].b, vq[i].cin,
              vq[i].res, vq[i].hi, vq[i].czn, vq[i].lat, 0);
    end

    // AND start while a long operation is in flight is dropped.
    run_vec("ign_shl", OP_SHL, 8'h81, 8'h07, 1'b0, 8'h80, 8'h00, 3'b100, 8, 2);
`ifdef ALU_SEQ_MUL_EN
    run_vec("ign_mul", OP_MUL, 8'h10, 8'h10, 1'b0, 8'h00, 8'h01, 3'b001, 9, 3);
`endif

    // Back-to-back: a new start in the done cycle.
    launch(OP_SHL, 8'h81, 8'h02, 1'b0);
    wait_done(0, lat, bn, hold);
    chk("b2b first latency", 32'(lat), 32'(3));
    chk("b2b first result", 32'(result), 32'(8'h04));
    op = OP_AND; a = 8'hF0; b = 8'h3C; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b second done", 32'(done), 32'(1));
    chk("b2b second result", 32'(result), 32'(8'h30));
    chk("b2b second czn", 32'(czn), 32'(3'b000));
    @(posedge clk); #1;
    chk("b2b done_pulse", 32'(done), 32'(0));
    prev_res = 8'h30; prev_hi = '0; prev_czn = 3'b000;

    // rst and start together: rst wins.
    op = OP_ADD; a = 8'hFF; b = 8'h01; cin = 1'b0; rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_start done", 32'(done), 32'(0));
    chk("rst_start result", 32'(result), 32'(0));
    chk("rst_start czn", 32'(czn), 32'(0));
    prev_res = '0; prev_hi = '0; prev_czn = '0;
    @(posedge clk); #1;
    chk("rst_start no_late_done", 32'(done), 32'(0));

    // Reset in cycle T+4 of a long operation aborts it.
    run_vec("pre_abort", OP_ADD, 8'h12, 8'h34, 1'b0, 8'h46, 8'h00, 3'b000, 1, 0);
`ifdef ALU_SEQ_MUL_EN
    launch(OP_MUL, 8'h10, 8'h10, 1'b0);
`else
    launch(OP_SHL, 8'h81, 8'h07, 1'b0);
`endif
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort busy_before", 32'(busy), 32'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'(0));
    chk("abort done", 32'(done), 32'(0));
    chk("abort result", 32'(result), 32'(0));
    chk("abort result_hi", 32'(result_hi), 32'(0));
    chk("abort czn", 32'(czn), 32'(0));
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dn++;
      @(posedge clk); #1;
    end
    chk("abort no_done", 32'(dn), 32'(0));
    prev_res = '0; prev_hi = '0; prev_czn = '0;
    run_vec("post_abort", OP_ADD, 8'h12, 8'h34, 1'b1, 8'h47, 8'h00, 3'b000, 1, 0);

    for (int i = 0; i < 150; i++) begin
      o  = 3'($urandom_range(0, 7));
      x  = W'($urandom);
      y  = W'($urandom);
      ci = 1'($urandom);
      model(o, x, y, ci, er, eh, ef, el);
      run_vec($sformatf("rnd%0d op%0d", i, o), o, x, y, ci, er, eh, ef, el, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
